// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame-length constants and the
// parity helper, kept here so the matching receiver can reuse them.
// Optional parity support is selected with the UART_SENDER_PARITY_EN macro.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int FRAME_BITS_8N1 = 10;
    localparam int FRAME_BITS_8E1 = 11;

    localparam logic [2:0] LAST_BIT_IDX = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Even parity bit: makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: counts 0..DIV-1 and pulses tick on the last count.
// restart forces the count back to 0 so a new frame starts on a full period.
module uart_baud_gen #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Free-running period counter, restarted on each accepted byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (restart) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (cnt_q == LAST) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_sender.sv
// UART transmitter: 8 data bits, LSB first, one stop bit.
// Define UART_SENDER_PARITY_EN to insert an even-parity bit after the data
// (8E1 frames); without it frames are plain 8N1.
module uart_sender
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [UART_DATA_BITS-1:0] UART_TXD,
    input  logic                      TX_EN,
    output logic                      TX_STATUS,
    output logic                      tx
);

    localparam int DIV = CLK_FREQ / BAUD;

    uart_state_e               state_q;
    logic [UART_DATA_BITS-1:0] data_q;
    logic [2:0]                bit_idx_q;
    logic                      tx_q;
    logic                      status_q;

    logic       accept_s;
    logic       tick_s;
    logic [2:0] nxt_idx_s;

    assign accept_s  = (state_q == ST_IDLE) && TX_EN;
    assign nxt_idx_s = bit_idx_q + 3'd1;

    uart_baud_gen #(
        .DIV(DIV)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .restart(accept_s),
        .tick   (tick_s)
    );

    // Frame sequencer with registered line and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            data_q    <= {UART_DATA_BITS{1'b0}};
            bit_idx_q <= 3'd0;
            tx_q      <= 1'b1;
            status_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (TX_EN) begin
                        // Byte is captured here; later UART_TXD changes are ignored.
                        data_q    <= UART_TXD;
                        bit_idx_q <= 3'd0;
                        tx_q      <= 1'b0;
                        status_q  <= 1'b0;
                        state_q   <= ST_START;
                    end else begin
                        tx_q     <= 1'b1;
                        status_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        bit_idx_q <= 3'd0;
                        tx_q      <= data_q[0];
                        state_q   <= ST_DATA;
                    end else begin
                        tx_q <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        if (bit_idx_q == LAST_BIT_IDX) begin
                            bit_idx_q <= 3'd0;
`ifdef UART_SENDER_PARITY_EN
                            tx_q    <= even_parity(data_q);
                            state_q <= ST_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
`endif
                        end else begin
                            bit_idx_q <= nxt_idx_s;
                            tx_q      <= data_q[nxt_idx_s];
                        end
                    end else begin
                        tx_q <= data_q[bit_idx_q];
                    end
                end
`ifdef UART_SENDER_PARITY_EN
                ST_PARITY: begin
                    if (tick_s) begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end else begin
                        tx_q <= even_parity(data_q);
                    end
                end
`endif
                ST_STOP: begin
                    if (tick_s) begin
                        // Status rises as the state returns to idle.
                        status_q <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                    tx_q <= 1'b1;
                end
                default: begin
                    bit_idx_q <= 3'd0;
                    tx_q      <= 1'b1;
                    status_q  <= 1'b1;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx        = tx_q;
    assign TX_STATUS = status_q;

endmodule

// File: tb/tb_uart_sender.sv
// Directed bench for uart_sender with CLK_FREQ=16, BAUD=1 (16 cycles per bit).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart_sender;

    localparam int DIV = 16;
`ifdef UART_SENDER_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] UART_TXD;
    logic       TX_EN;
    logic       TX_STATUS;
    logic       tx;

    int total;
    int bad;

    typedef struct {
        logic [7:0] data;
        logic [0:9] frame;   // start, d0..d7, stop in line order
        logic       par;     // even parity of data
        bit         scramble;
    } vec_t;

    vec_t vecs[6];

    uart_sender #(
        .CLK_FREQ(16),
        .BAUD    (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .UART_TXD (UART_TXD),
        .TX_EN    (TX_EN),
        .TX_STATUS(TX_STATUS),
        .tx       (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic exp_bit(input logic [0:9] f, input logic p, input int idx);
`ifdef UART_SENDER_PARITY_EN
        if (idx < 9) return f[idx];
        else if (idx == 9) return p;
        else return 1'b1;
`else
        if (idx < 10) return f[idx];
        else return p;
`endif
    endfunction

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {tx,TX_STATUS}=%b expected %b", name, act, exp);
        end
    endtask

    // Caller is positioned just after a falling edge; the next rising edge accepts.
    task automatic run_frame(input string name, input logic [7:0] data, input logic [0:9] frame,
                             input logic par, input bit hold, input bit scramble, input int inject_j);
        bit   bit_bad;
        bit   st_bad;
        logic e;
        check({name, "_ready"}, {tx, TX_STATUS}, 2'b11);
        UART_TXD = data;
        TX_EN    = 1'b1;
        @(posedge clk);
        st_bad = 1'b0;
        for (int b = 0; b < NB; b++) begin
            bit_bad = 1'b0;
            e = exp_bit(frame, par, b);
            for (int c = 0; c < DIV; c++) begin
                @(negedge clk);
                if (tx !== e) bit_bad = 1'b1;
                if (TX_STATUS !== 1'b0) st_bad = 1'b1;
                TX_EN = hold;
                if (scramble) UART_TXD = 8'($urandom_range(0, 255));
                if (b * DIV + c == inject_j) begin
                    TX_EN    = 1'b1;
                    UART_TXD = 8'hFF;
                end
            end
            total++;
            if (bit_bad) begin
                bad++;
                $display("FAIL %s_bit%0d: tx differed from expected %b during the bit", name, b, e);
            end
        end
        total++;
        if (st_bad) begin
            bad++;
            $display("FAIL %s_busy: TX_STATUS was not 0 throughout the frame (expected 0)", name);
        end
        @(negedge clk);
        check({name, "_done"}, {tx, TX_STATUS}, 2'b11);
        if (!hold) begin
            TX_EN = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check({name, "_idle"}, {tx, TX_STATUS}, 2'b11);
            end
        end
    endtask

    initial begin
        bit   bb;
        logic e;

        total = 0;
        bad   = 0;

        vecs[0] = '{data: 8'h55, frame: 10'b0101010101, par: 1'b0, scramble: 1'b0};
        vecs[1] = '{data: 8'h3C, frame: 10'b0001111001, par: 1'b0, scramble: 1'b1};
        vecs[2] = '{data: 8'h07, frame: 10'b0111000001, par: 1'b1, scramble: 1'b0};
        vecs[3] = '{data: 8'h03, frame: 10'b0110000001, par: 1'b0, scramble: 1'b0};
        vecs[4] = '{data: 8'h81, frame: 10'b0100000011, par: 1'b0, scramble: 1'b0};
        vecs[5] = '{data: 8'hFF, frame: 10'b0111111111, par: 1'b0, scramble: 1'b1};

        reset    = 1'b0;
        UART_TXD = 8'h00;
        TX_EN    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {tx, TX_STATUS}, 2'b11);
        reset = 1'b1;
        @(negedge clk);
        check("post_release", {tx, TX_STATUS}, 2'b11);

        // Table of single frames.
        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].frame, vecs[i].par,
                      1'b0, vecs[i].scramble, -1);
        end

        // Second request at cycle 40 during a frame must be dropped.
        run_frame("ignore", 8'hA3, 10'b0110001011, 1'b0, 1'b0, 1'b0, 39);

        // TX_EN held high: two frames with one idle cycle between them.
        run_frame("b2b_a", 8'h00, 10'b0000000001, 1'b0, 1'b1, 1'b0, -1);
        run_frame("b2b_b", 8'h81, 10'b0100000011, 1'b0, 1'b0, 1'b0, -1);

        // Reset at cycle 70 of a 0x0F frame, then a clean frame.
        UART_TXD = 8'h0F;
        TX_EN    = 1'b1;
        @(posedge clk);
        bb = 1'b0;
        for (int j = 0; j <= 70; j++) begin
            @(negedge clk);
            TX_EN = 1'b0;
            e = exp_bit(10'b0111100001, 1'b0, j / DIV);
            if (tx !== e) bb = 1'b1;
        end
        total++;
        if (bb) begin
            bad++;
            $display("FAIL abort_prefix: tx differed from 0x0F frame before reset (expected match)");
        end
        check("abort_busy", {tx, TX_STATUS}, 2'b10);
        #2;
        reset = 1'b0;
        #1;
        check("abort_async", {tx, TX_STATUS}, 2'b11);
        @(negedge clk);
        check("abort_held", {tx, TX_STATUS}, 2'b11);
        reset = 1'b1;
        run_frame("after_reset", 8'h0F, 10'b0111100001, 1'b0, 1'b0, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_sender.md
UART_SENDER -- requirements
Module: uart_sender

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, SHALL be the clk frequency in Hz.
REQ-002 Parameter BAUD, default 9600, SHALL be the serial bit rate in bit/s.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous active-low reset (0 = reset).
REQ-006 UART_TXD  input  8  SHALL be the byte from the core, sampled only when TX_EN=1 and TX_STATUS=1.
REQ-007 TX_EN  input  1  SHALL be the one-cycle send request from the core.
REQ-008 TX_STATUS  output  1  SHALL be 1 when idle and able to accept a byte, 0 while busy.
REQ-009 tx  output  1  SHALL be the serial line, idle high.

Function
REQ-010 Bit period SHALL be DIV = CLK_FREQ/BAUD clk cycles (integer division); the divider SHALL count 0..DIV-1 and restart at 0 on each accepted byte.
REQ-011 States SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-012 IDLE: tx=1, TX_STATUS=1; TX_EN=1 SHALL latch UART_TXD into a shift register and go to START on the same edge.
REQ-013 TX_STATUS SHALL drop to 0 on the cycle after acceptance and stay 0 until the state returns to IDLE.
REQ-014 START SHALL drive tx=0 for exactly DIV cycles, then go to DATA.
REQ-015 DATA SHALL drive bits LSB first, each for DIV cycles, using a 3-bit index from 0 to 7; after bit 7 SHALL go to PARITY if enabled, else to STOP.
REQ-016 STOP SHALL drive tx=1 for DIV cycles, then return to IDLE; a byte is 10*DIV cycles (11*DIV with parity) from acceptance to TX_STATUS=1.
REQ-017 TX_EN while TX_STATUS=0 SHALL be ignored: no latch, no state change, no queueing.
REQ-018 UART_TXD changes after acceptance SHALL NOT affect the frame in flight.
REQ-019 TX_EN held high continuously SHALL send back-to-back frames, each new byte sampled on the first IDLE cycle, with one idle cycle (tx=1) between frames.
REQ-020 tx SHALL be registered (glitch-free), with first start-bit low visible one cycle after acceptance.

Reset
REQ-021 With reset=0, the block SHALL go to IDLE immediately and asynchronously: tx=1, TX_STATUS=1, divider=0, bit index=0, shift register=0.
REQ-022 Reset during a frame SHALL abort it; the partial frame is not resumed, and the first edge after release SHALL act as IDLE.

Configuration
REQ-023 Macro UART_SENDER_PARITY_EN defined SHALL insert a PARITY state after DATA that drives the even-parity bit (XOR of the 8 data bits) for DIV cycles.
REQ-024 Without UART_SENDER_PARITY_EN, there SHALL be no PARITY state or logic, and frames SHALL be 8N1.

Structure
REQ-025 State encoding (IDLE, START, DATA, PARITY, STOP) and frame-length constants SHALL be in the shared package uart_pkg, for reuse by the matching receiver.
REQ-026 The bit-period counter SHALL be a sub-module uart_baud_gen (inputs clk, reset, restart; output tick, one cycle every DIV).

Verification
REQ-027 CLK_FREQ=16, BAUD=1 (DIV=16), send 0x55 -> tx sequence 0,1,0,1,0,1,0,1,0,1 at 16 cycles per bit; TX_STATUS=1 again at cycle 160.
REQ-028 Send 0xA3, then pulse TX_EN with 0xFF at cycle 40 -> second request ignored; only the 0xA3 frame (bits 1,1,0,0,0,1,0,1) appears.
REQ-029 TX_EN held high, UART_TXD=0x00 then 0x81 -> two back-to-back frames with exactly one idle-high cycle between them.
REQ-030 Reset asserted at cycle 70 of a 0x0F frame -> tx=1 and TX_STATUS=1 in the same cycle; next TX_EN starts a clean frame.
REQ-031 With UART_SENDER_PARITY_EN, send 0x07 -> parity bit 1, frame 11*DIV cycles; send 0x03 -> parity bit 0.
REQ-032 Change UART_TXD every cycle after accepting 0x3C -> serialized data is still 0x3C.
